// File: rtl/gr_write_sched.sv
// gr_write_sched: write scheduler for the 8-bit general register (GR).
// Arbitrates the single GR write port between requester A (decoder immediates) and
// requester B (ALU writeback), and drives the GR nibble-load strobes and data bus.
// Split-byte writes (mode 00) go out as a low-nibble write followed by a high-nibble
// write on the next cycle.
//
// Ports:
//   clk, rst            - clock; synchronous active-high reset
//   a_req/a_mode/a_data - requester A request, mode, data; a_ack one-cycle grant pulse
//   b_req/b_mode/b_data - requester B request, mode, data; b_ack one-cycle grant pulse
//   lsb_on_gr           - GR low-nibble load strobe
//   msb_on_gr           - GR high-nibble load strobe
//   bus_2_gr            - data to the GR (high nibble is presented on bus[3:0])
//   busy                - high while a write is in flight (ISSUE or HIGH)
//
// Parameter RR_EN: 1 = round-robin arbitration, 0 = fixed priority with A winning.
module gr_write_sched #(
    parameter bit RR_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_req,
    input  logic [1:0] a_mode,
    input  logic [7:0] a_data,
    output logic       a_ack,
    input  logic       b_req,
    input  logic [1:0] b_mode,
    input  logic [7:0] b_data,
    output logic       b_ack,
    output logic       lsb_on_gr,
    output logic       msb_on_gr,
    output logic [7:0] bus_2_gr,
    output logic       busy
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StHigh  = 2'd2
    } state_e;

    localparam logic [1:0] ModeSplit = 2'b00;
    localparam logic [1:0] ModeLow   = 2'b01;
    localparam logic [1:0] ModeHigh  = 2'b10;
    localparam logic [1:0] ModeByte  = 2'b11;

    state_e     r_state, w_state_d;
    logic       r_split, w_split_d;      // latched write is a split byte
    logic [3:0] r_data_hi, w_data_hi_d;  // high nibble kept for the HIGH phase
    logic       r_prio_b, w_prio_b_d;    // 1 = B wins the next contended grant

    logic       r_a_ack, w_a_ack;
    logic       r_b_ack, w_b_ack;
    logic       r_lsb, w_lsb;
    logic       r_msb, w_msb;
    logic [7:0] r_bus, w_bus;
    logic       r_busy, w_busy;

    logic       w_grant_b;
    logic [1:0] w_sel_mode;
    logic [7:0] w_sel_data;

    // B wins if it is alone, or if both request and round-robin says it is B's turn.
    assign w_grant_b  = b_req && (!a_req || (RR_EN && r_prio_b));
    assign w_sel_mode = w_grant_b ? b_mode : a_mode;
    assign w_sel_data = w_grant_b ? b_data : a_data;

    // Next-state and next-output logic; outputs are registered, so the values computed
    // here appear during the cycle that the new state is occupied.
    always_comb begin
        w_state_d   = r_state;
        w_split_d   = r_split;
        w_data_hi_d = r_data_hi;
        w_prio_b_d  = r_prio_b;
        w_a_ack     = 1'b0;
        w_b_ack     = 1'b0;
        w_lsb       = 1'b0;
        w_msb       = 1'b0;
        w_bus       = 8'h00;

        case (r_state)
            StIdle: begin
                if (a_req || b_req) begin
                    w_state_d   = StIssue;
                    w_split_d   = (w_sel_mode == ModeSplit);
                    w_data_hi_d = w_sel_data[7:4];
                    w_prio_b_d  = !w_grant_b;
                    w_a_ack     = !w_grant_b;
                    w_b_ack     = w_grant_b;
                    case (w_sel_mode)
                        ModeLow, ModeSplit: begin
                            w_lsb = 1'b1;
                            w_bus = {4'h0, w_sel_data[3:0]};
                        end
                        ModeHigh: begin
                            w_msb = 1'b1;
                            w_bus = {4'h0, w_sel_data[7:4]};
                        end
                        ModeByte: begin
                            w_lsb = 1'b1;
                            w_msb = 1'b1;
                            w_bus = w_sel_data;
                        end
                        default: ;
                    endcase
                end
            end
            StIssue: begin
                if (r_split) begin
                    w_state_d = StHigh;
                    w_msb     = 1'b1;
                    w_bus     = {4'h0, r_data_hi};
                end else begin
                    w_state_d = StIdle;
                end
            end
            StHigh:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase

        w_busy = (w_state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_split   <= 1'b0;
            r_data_hi <= 4'h0;
            r_prio_b  <= 1'b0;
            r_a_ack   <= 1'b0;
            r_b_ack   <= 1'b0;
            r_lsb     <= 1'b0;
            r_msb     <= 1'b0;
            r_bus     <= 8'h00;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_split   <= w_split_d;
            r_data_hi <= w_data_hi_d;
            r_prio_b  <= w_prio_b_d;
            r_a_ack   <= w_a_ack;
            r_b_ack   <= w_b_ack;
            r_lsb     <= w_lsb;
            r_msb     <= w_msb;
            r_bus     <= w_bus;
            r_busy    <= w_busy;
        end
    end

    assign a_ack     = r_a_ack;
    assign b_ack     = r_b_ack;
    assign lsb_on_gr = r_lsb;
    assign msb_on_gr = r_msb;
    assign bus_2_gr  = r_bus;
    assign busy      = r_busy;

endmodule
